// File: rtl/control_unit_pkg.sv
// Shared types for the accumulator-core control unit: opcodes, FSM states, ALU selects
// and the decoded instruction classes, plus the memory-wait timer sizing.
package control_unit_pkg;

  localparam int OPC_W   = 4;
  localparam int TIMEOUT = 15;
  localparam int WAIT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_NOT = 4'h7,
    OP_LSL = 4'h8,
    OP_LSR = 4'h9,
    OP_JMP = 4'hA,
    OP_JZ  = 4'hB,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_MEMWR  = 3'd3,
    ST_HALT   = 3'd4
  } ctrl_state_t;

  // FnNOP passes ACC through unchanged; FnMem passes the memory operand.
  typedef enum logic [3:0] {
    FnNOP = 4'd0,
    FnMem = 4'd1,
    FnADD = 4'd2,
    FnSUB = 4'd3,
    FnAND = 4'd4,
    FnOR  = 4'd5,
    FnNOT = 4'd6,
    FnLSL = 4'd7,
    FnLSR = 4'd8
  } alu_functions_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_REG     = 3'd1,
    CLS_MEMRD   = 3'd2,
    CLS_MEMWR   = 3'd3,
    CLS_JMP     = 3'd4,
    CLS_JZ      = 3'd5,
    CLS_HLT     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

endpackage

// File: rtl/control_unit_op_decode.sv
// Combinational opcode decoder: maps the IR opcode to an ALU function and an instruction class.
// Zero latency; no handshake, the result is only consumed in DECODE and on memory-read ack.
module control_unit_op_decode
  import control_unit_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output alu_functions_t   o_function,
  output op_class_t        o_class
);

  always_comb begin
    o_function = FnNOP;
    o_class    = CLS_ILLEGAL;
    case (opcode_t'(i_opcode))
      OP_NOP: o_class = CLS_NOP;
      OP_LDA: begin o_class = CLS_MEMRD; o_function = FnMem; end
      OP_STA: o_class = CLS_MEMWR;
      OP_ADD: begin o_class = CLS_MEMRD; o_function = FnADD; end
      OP_SUB: begin o_class = CLS_MEMRD; o_function = FnSUB; end
      OP_AND: begin o_class = CLS_MEMRD; o_function = FnAND; end
      OP_OR:  begin o_class = CLS_MEMRD; o_function = FnOR;  end
      OP_NOT: begin o_class = CLS_REG;   o_function = FnNOT; end
      OP_LSL: begin o_class = CLS_REG;   o_function = FnLSL; end
      OP_LSR: begin o_class = CLS_REG;   o_function = FnLSR; end
      OP_JMP: o_class = CLS_JMP;
      OP_JZ:  o_class = CLS_JZ;
      OP_HLT: o_class = CLS_HLT;
      default: o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit accumulator core (fetch, decode, memory operand, halt).
// Reg-only ops take 2 cycles, memory ops 3; requests are held until MemAck or a timeout fault.
module control_unit
  import control_unit_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_zflag,
  input  logic             i_mem_ack,
  output alu_functions_t   o_function,
  output logic             o_load_acc,
  output logic             o_load_ir,
  output logic             o_pc_inc,
  output logic             o_load_pc,
  output logic             o_addr_sel,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_halted,
  output logic             o_fault
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_fault;
  alu_functions_t    w_dec_function;
  op_class_t         w_dec_class;
  logic              w_req;
  logic              w_ack;
  logic              w_timeout;

  control_unit_op_decode u_op_decode (
    .i_opcode   (i_opcode),
    .o_function (w_dec_function),
    .o_class    (w_dec_class)
  );

  assign w_req     = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign w_ack     = w_req && i_mem_ack;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign w_timeout = w_req && !i_mem_ack && (r_wait_cnt == WAIT_W'(TIMEOUT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_ack) begin
          w_next_state = ST_DECODE;
        end else if (w_timeout) begin
          w_next_state = ST_HALT;
        end
      end
      ST_DECODE: begin
        case (w_dec_class)
          CLS_MEMRD:           w_next_state = ST_MEMRD;
          CLS_MEMWR:           w_next_state = ST_MEMWR;
          CLS_HLT, CLS_ILLEGAL: w_next_state = ST_HALT;
          default:             w_next_state = ST_FETCH;
        endcase
      end
      ST_MEMRD, ST_MEMWR: begin
        if (w_ack) begin
          w_next_state = ST_FETCH;
        end else if (w_timeout) begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    o_function  = FnNOP;
    o_load_acc  = 1'b0;
    o_load_ir   = 1'b0;
    o_pc_inc    = 1'b0;
    o_load_pc   = 1'b0;
    o_addr_sel  = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_halted    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        o_mem_read = 1'b1;
        o_load_ir  = i_mem_ack;
        o_pc_inc   = i_mem_ack;
      end
      ST_DECODE: begin
        case (w_dec_class)
          CLS_REG: begin
            o_function = w_dec_function;
            o_load_acc = 1'b1;
          end
          CLS_JMP: o_load_pc = 1'b1;
          CLS_JZ:  o_load_pc = i_zflag;
          default: ;
        endcase
      end
      ST_MEMRD: begin
        o_addr_sel = 1'b1;
        o_mem_read = 1'b1;
        if (i_mem_ack) begin
          o_function = w_dec_function;
          o_load_acc = 1'b1;
        end
      end
      ST_MEMWR: begin
        o_addr_sel  = 1'b1;
        o_mem_write = 1'b1;
      end
      ST_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts whenever a new request phase begins or a handshake completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_ack || (w_next_state != r_state)) begin
      r_wait_cnt <= '0;
    end else if (w_req) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault <= 1'b0;
    end else if (w_timeout || ((r_state == ST_DECODE) && (w_dec_class == CLS_ILLEGAL))) begin
      r_fault <= 1'b1;
    end
  end

  assign o_fault = r_fault;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus randomized instruction streams
// checked cycle by cycle against an instruction-level timing model.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam logic [8:0] S_LACC = 9'h100;
  localparam logic [8:0] S_LIR  = 9'h080;
  localparam logic [8:0] S_PCI  = 9'h040;
  localparam logic [8:0] S_LPC  = 9'h020;
  localparam logic [8:0] S_ASEL = 9'h010;
  localparam logic [8:0] S_MRD  = 9'h008;
  localparam logic [8:0] S_MWR  = 9'h004;
  localparam logic [8:0] S_HLT  = 9'h002;
  localparam logic [8:0] S_FLT  = 9'h001;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b1;
  logic [3:0]     opcode  = 4'h0;
  logic           zflag   = 1'b0;
  logic           mem_ack = 1'b0;
  alu_functions_t fn;
  logic           load_acc, load_ir, pc_inc, load_pc, addr_sel;
  logic           mem_read, mem_write, halted, fault;
  logic [12:0]    obs;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_opcode    (opcode),
    .i_zflag     (zflag),
    .i_mem_ack   (mem_ack),
    .o_function  (fn),
    .o_load_acc  (load_acc),
    .o_load_ir   (load_ir),
    .o_pc_inc    (pc_inc),
    .o_load_pc   (load_pc),
    .o_addr_sel  (addr_sel),
    .o_mem_read  (mem_read),
    .o_mem_write (mem_write),
    .o_halted    (halted),
    .o_fault     (fault)
  );

  assign obs = {fn, load_acc, load_ir, pc_inc, load_pc, addr_sel, mem_read, mem_write, halted, fault};

  function automatic logic [12:0] pk(alu_functions_t f, logic [8:0] s);
    return {f, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a rising edge with the core in its first FETCH cycle.
  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    zflag   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    mem_ack  = 1'b0;
    #1;
    checks++;
    if (obs !== pk(FnNOP, S_MRD)) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs, pk(FnNOP, S_MRD));
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_lda_ack_tied();
    logic [12:0] e [4];
    e[0] = pk(FnNOP, S_MRD | S_LIR | S_PCI);
    e[1] = pk(FnNOP, 9'h0);
    e[2] = pk(FnMem, S_ASEL | S_MRD | S_LACC);
    e[3] = pk(FnNOP, S_MRD | S_LIR | S_PCI);
    do_reset();
    opcode  = 4'h1;
    mem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      zflag = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== e[c]) begin
        errors++;
        $display("FAIL lda_tied cyc%0d got %h exp %h", c, obs, e[c]);
      end
      tick();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_jz();
    logic [12:0] e [3];
    logic        ack [3];
    for (int z = 1; z >= 0; z--) begin
      e[0] = pk(FnNOP, S_MRD | S_LIR | S_PCI); ack[0] = 1'b1;
      e[1] = pk(FnNOP, (z == 1) ? S_LPC : 9'h0); ack[1] = 1'b0;
      e[2] = pk(FnNOP, S_MRD); ack[2] = 1'b0;
      do_reset();
      opcode = 4'hB;
      for (int c = 0; c < 3; c++) begin
        mem_ack = ack[c];
        zflag   = (c == 1) ? (z == 1) : 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs !== e[c]) begin
          errors++;
          $display("FAIL jz z=%0d cyc%0d got %h exp %h", z, c, obs, e[c]);
        end
        tick();
      end
    end
  endtask

  task automatic test_sta_delay();
    logic [12:0] e [7];
    logic        ack [7];
    e[0] = pk(FnNOP, S_MRD | S_LIR | S_PCI); ack[0] = 1'b1;
    e[1] = pk(FnNOP, 9'h0);                   ack[1] = 1'b0;
    for (int c = 2; c < 6; c++) begin
      e[c]   = pk(FnNOP, S_ASEL | S_MWR);
      ack[c] = (c == 5);
    end
    e[6] = pk(FnNOP, S_MRD); ack[6] = 1'b0;
    do_reset();
    opcode = 4'h2;
    for (int c = 0; c < 7; c++) begin
      mem_ack = ack[c];
      zflag   = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== e[c]) begin
        errors++;
        $display("FAIL sta_delay cyc%0d got %h exp %h", c, obs, e[c]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    logic [12:0] e;
    do_reset();
    opcode = 4'h0;
    for (int c = 0; c < 19; c++) begin
      mem_ack = (c >= 17) ? 1'($urandom) : 1'b0;
      e = (c < 16) ? pk(FnNOP, S_MRD) : pk(FnNOP, S_HLT | S_FLT);
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout_fault cyc%0d got %h exp %h", c, obs, e);
      end
      tick();
    end
    do_reset();
    for (int c = 0; c < 18; c++) begin
      mem_ack = (c == 15);
      if (c < 15)       e = pk(FnNOP, S_MRD);
      else if (c == 15) e = pk(FnNOP, S_MRD | S_LIR | S_PCI);
      else if (c == 16) e = pk(FnNOP, 9'h0);
      else              e = pk(FnNOP, S_MRD);
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout_last_ack cyc%0d got %h exp %h", c, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_halt_states();
    logic [12:0] e;
    logic [3:0]  ops [2];
    ops[0] = 4'hC;
    ops[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      opcode = ops[i];
      for (int c = 0; c < 6; c++) begin
        mem_ack = (c == 0) ? 1'b1 : ((c == 1) ? 1'b0 : 1'($urandom));
        zflag   = 1'($urandom);
        if (c == 0)      e = pk(FnNOP, S_MRD | S_LIR | S_PCI);
        else if (c == 1) e = pk(FnNOP, 9'h0);
        else             e = pk(FnNOP, S_HLT | ((i == 0) ? S_FLT : 9'h0));
        @(negedge clk);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL halt op=%h cyc%0d got %h exp %h", ops[i], c, obs, e);
        end
        tick();
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (obs !== pk(FnNOP, S_MRD)) begin
        errors++;
        $display("FAIL halt_release op=%h got %h exp %h", ops[i], obs, pk(FnNOP, S_MRD));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] e;
    do_reset();
    opcode = 4'h1;
    for (int c = 0; c < 7; c++) begin
      mem_ack = (c == 0);
      if (c == 0)      e = pk(FnNOP, S_MRD | S_LIR | S_PCI);
      else if (c == 1) e = pk(FnNOP, 9'h0);
      else             e = pk(FnNOP, S_ASEL | S_MRD);
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_memrd cyc%0d got %h exp %h", c, obs, e);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== pk(FnNOP, S_MRD)) begin
      errors++;
      $display("FAIL mid_reset_drop got %h exp %h", obs, pk(FnNOP, S_MRD));
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      mem_ack = (c == 15);
      e = (c == 15) ? pk(FnNOP, S_MRD | S_LIR | S_PCI) : pk(FnNOP, S_MRD);
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL after_mid_reset cyc%0d got %h exp %h", c, obs, e);
      end
      tick();
    end
  endtask

  // Instruction-level model: each instruction is a fetch wait, one decode cycle, and an optional operand wait.
  task automatic test_random();
    int             d;
    int             dm;
    int             kind;
    logic [3:0]     op;
    logic           z;
    alu_functions_t mfn;
    logic [12:0]    e;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      d  = ($urandom_range(0, 9) == 0) ? (15 + $urandom_range(0, 1)) : $urandom_range(0, 3);
      for (int k = 0; k <= d && k < 16; k++) begin
        opcode  = 4'($urandom);
        mem_ack = (k == d);
        zflag   = 1'($urandom);
        e = (k == d) ? pk(FnNOP, S_MRD | S_LIR | S_PCI) : pk(FnNOP, S_MRD);
        @(negedge clk);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rnd_fetch n=%0d k=%0d got %h exp %h", n, k, obs, e);
        end
        tick();
      end
      if (d == 16) begin
        mem_ack = 1'($urandom);
        @(negedge clk);
        checks++;
        if (obs !== pk(FnNOP, S_HLT | S_FLT)) begin
          errors++;
          $display("FAIL rnd_fetch_timeout n=%0d got %h exp %h", n, obs, pk(FnNOP, S_HLT | S_FLT));
        end
        do_reset();
        continue;
      end
      opcode  = op;
      mem_ack = 1'($urandom);
      z       = 1'($urandom);
      zflag   = z;
      kind    = 0;
      mfn     = FnNOP;
      e       = pk(FnNOP, 9'h0);
      case (op)
        4'h0: kind = 0;
        4'h1: begin kind = 1; mfn = FnMem; end
        4'h2: kind = 2;
        4'h3: begin kind = 1; mfn = FnADD; end
        4'h4: begin kind = 1; mfn = FnSUB; end
        4'h5: begin kind = 1; mfn = FnAND; end
        4'h6: begin kind = 1; mfn = FnOR;  end
        4'h7: e = pk(FnNOT, S_LACC);
        4'h8: e = pk(FnLSL, S_LACC);
        4'h9: e = pk(FnLSR, S_LACC);
        4'hA: e = pk(FnNOP, S_LPC);
        4'hB: e = pk(FnNOP, z ? S_LPC : 9'h0);
        4'hF: kind = 3;
        default: kind = 4;
      endcase
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL rnd_decode n=%0d op=%h got %h exp %h", n, op, obs, e);
      end
      tick();
      if (kind == 1 || kind == 2) begin
        dm = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
        for (int k = 0; k <= dm; k++) begin
          mem_ack = (k == dm);
          zflag   = 1'($urandom);
          if (kind == 2)    e = pk(FnNOP, S_ASEL | S_MWR);
          else if (k == dm) e = pk(mfn, S_ASEL | S_MRD | S_LACC);
          else              e = pk(FnNOP, S_ASEL | S_MRD);
          @(negedge clk);
          checks++;
          if (obs !== e) begin
            errors++;
            $display("FAIL rnd_mem n=%0d op=%h k=%0d got %h exp %h", n, op, k, obs, e);
          end
          tick();
        end
      end else if (kind >= 3) begin
        mem_ack = 1'($urandom);
        e = pk(FnNOP, S_HLT | ((kind == 4) ? S_FLT : 9'h0));
        @(negedge clk);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL rnd_halt n=%0d op=%h got %h exp %h", n, op, obs, e);
        end
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lda_ack_tied();
    test_jz();
    test_sta_delay();
    test_timeout();
    test_halt_states();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
